// File: rtl/ifetch.sv
// ifetch: instruction fetch front end.
//   Issues sequential word-aligned fetches from a fetch PC, tracks the number of
//   outstanding requests, buffers returned words with their PCs in a DEPTH-entry
//   FIFO, and hands them to decode with a valid/ready handshake. A redirect
//   flushes the buffer, reloads the PC and drops every stale beat still in flight.
//
//   Optional feature: define IFETCH_BYPASS_EN to forward a response straight to
//   o_inst/o_inst_valid in the same cycle when the buffer is empty.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_imem_req_valid/_addr       fetch request to instruction memory
//   i_imem_req_ready             memory accepts the request
//   i_imem_resp_valid/_rdata     in-order response beats
//   o_inst_valid/o_inst/o_inst_pc  instruction offered to decode
//   i_inst_ready                 decode consumes the offered instruction
//   i_redirect_valid/_pc         taken branch/jump: flush and refetch
module ifetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [31:0] RESET_PC = {RESET_ADDR[31:2], 2'b00};

    logic [31:0]   pc;          // next address to request
    logic [31:0]   resp_pc;     // PC of the next non-dropped response
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          accept, resp_live, resp_keep, bypass, push, pop, empty;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_pc;

    // Requests are always sequential between redirects, and a redirect drops
    // everything older, so the PC of each kept response is simply a running
    // counter (resp_pc) rather than a full queue of request PCs.
    assign redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign empty       = (count == '0);
    assign occupancy   = {1'b0, outstanding} + {1'b0, count};

    // Issue only while every in-flight word is guaranteed a buffer slot.
    assign o_imem_req_valid = !i_rst && !i_redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign o_imem_req_addr  = pc;
    assign accept           = o_imem_req_valid && i_imem_req_ready;

    // A beat with nothing outstanding is a protocol violation and is ignored.
    assign resp_live = i_imem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_live && (drop == '0);

`ifdef IFETCH_BYPASS_EN
    assign bypass    = resp_keep && empty;
    assign o_inst    = empty ? i_imem_resp_rdata : inst_mem[rd_ptr];
    assign o_inst_pc = empty ? resp_pc : pc_mem[rd_ptr];
`else
    assign bypass    = 1'b0;
    assign o_inst    = inst_mem[rd_ptr];
    assign o_inst_pc = pc_mem[rd_ptr];
`endif

    assign o_inst_valid = !i_rst && (!empty || bypass);

    // Redirect wins over push and pop; a bypassed word consumed this cycle is not stored.
    assign pop  = !empty && i_inst_ready && !i_redirect_valid;
    assign push = resp_keep && !i_redirect_valid && !(bypass && i_inst_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (i_redirect_valid) begin
            pc          <= redirect_pc;
            resp_pc     <= redirect_pc;
            outstanding <= outstanding + CW'(accept) - CW'(resp_live);
            // Everything still in flight after this cycle is stale.
            drop        <= outstanding + CW'(accept) - CW'(resp_live);
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (accept)
                pc <= pc + 32'd4;
            if (resp_keep)
                resp_pc <= resp_pc + 32'd4;
            outstanding <= outstanding + CW'(accept) - CW'(resp_live);
            if (resp_live && (drop != '0))
                drop <= drop - 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= i_imem_resp_rdata;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_ADDR, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: instruction buffer entries and maximum outstanding requests; power of two, at least 2.
REQ-003 SHALL have port i_clk, input, 1 bit: single global clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port o_imem_req_valid, output, 1 bit: fetch request pending.
REQ-006 SHALL have port i_imem_req_ready, input, 1 bit: memory accepts the request; a request is accepted on a cycle where valid and ready are both high.
REQ-007 SHALL have port o_imem_req_addr, output, 32 bits: word-aligned fetch address; bits [1:0] always 00.
REQ-008 SHALL have port i_imem_resp_valid, input, 1 bit: response beat; responses return in request order with latency of 1 or more cycles.
REQ-009 SHALL have port i_imem_resp_rdata, input, 32 bits: instruction word of the response.
REQ-010 SHALL have port o_inst_valid, output, 1 bit: instruction offered to decode.
REQ-011 SHALL have port i_inst_ready, input, 1 bit: decode consumes; a handshake occurs on a cycle where valid and ready are both high.
REQ-012 SHALL have port o_inst, output, 32 bits: unmodified instruction word.
REQ-013 SHALL have port o_inst_pc, output, 32 bits: address the offered word was fetched from.
REQ-014 SHALL have port i_redirect_valid, input, 1 bit: taken branch or jump; flush and refetch.
REQ-015 SHALL have port i_redirect_pc, input, 32 bits: new fetch PC; bits [1:0] ignored.

Function
REQ-016 SHALL hold a fetch PC register and advance it by 4 on each accepted request.
REQ-017 SHALL assert o_imem_req_valid when (outstanding + buffer occupancy) < DEPTH and i_redirect_valid is low.
REQ-018 SHALL drive o_imem_req_addr from the fetch PC; it may change while the request is unaccepted only due to a redirect.
REQ-019 SHALL keep an outstanding counter of width clog2(DEPTH+1): +1 per accepted request, -1 per response beat, both in the same cycle giving net 0.
REQ-020 SHALL write each non-dropped response into a DEPTH-entry FIFO along with its PC; the response PC is tracked by an in-order PC queue or equivalent.
REQ-021 SHALL present the FIFO head on o_inst and o_inst_pc, with o_inst_valid = FIFO non-empty; a handshake pops the head.
REQ-022 SHALL hold o_inst and o_inst_pc stable while o_inst_valid is high and i_inst_ready is low.
REQ-023 SHALL allow a simultaneous push and pop when full; the result is that the FIFO remains full.
REQ-024 SHALL, on i_redirect_valid, empty the FIFO by the next cycle, load fetch PC = {i_redirect_pc[31:2],2'b00}, and set drop counter = outstanding + (request accepted this cycle) - (response this cycle).
REQ-025 SHALL discard response beats while the drop counter is nonzero, decrementing the counter per beat; discarded beats never reach o_inst.
REQ-026 SHALL start the first post-redirect request no earlier than the cycle after the redirect; the redirect has priority over push, pop and issue in that cycle.
REQ-027 SHALL restart the drop count on a redirect that arrives while dropping, using the rule in REQ-024.
REQ-028 SHALL ignore a response with zero outstanding (protocol violation); the response SHALL NOT be pushed.
REQ-029 SHALL wrap PC arithmetic modulo 2^32, so 32'hFFFFFFFC + 4 = 0.

Reset
REQ-030 SHALL, while i_rst is high, drive o_imem_req_valid=0 and o_inst_valid=0, make the FIFO empty, and set outstanding=0, drop=0 and fetch PC=RESET_ADDR.
REQ-031 SHALL, on the first cycle after reset release, drive o_imem_req_valid=1 with addr=RESET_ADDR.
REQ-032 SHALL treat reset mid-operation as aborting all in-flight requests; late responses after reset are ignored under REQ-028.

Configuration
REQ-033 SHALL use macro IFETCH_BYPASS_EN to control response bypass.
REQ-034 SHALL, when IFETCH_BYPASS_EN is defined and the FIFO is empty, forward a non-dropped response combinationally to o_inst/o_inst_valid in the same cycle; if consumed, it is not pushed.
REQ-035 SHALL, when IFETCH_BYPASS_EN is undefined, route every response through the FIFO, giving o_inst_valid 1 cycle after resp_valid at the earliest.

Verification
REQ-036 Reset release with ready=1, 1-cycle latency memory, decode ready=1 -> addrs 0,4,8,... issued; o_inst_pc sequence 0,4,8; no gaps in steady state.
REQ-037 i_inst_ready=0 for 10 cycles -> at most DEPTH=4 requests outstanding+buffered; req_valid drops; o_inst/o_inst_pc held at pc 0.
REQ-038 Redirect to 32'h00000102 with 3 outstanding -> next request addr 32'h00000100; the 3 stale responses are dropped; first o_inst_pc = 32'h00000100.
REQ-039 i_imem_req_ready low 5 cycles -> addr held stable; no PC advance; resumes at the same addr.
REQ-040 Second redirect (to 32'h200) during a drop window -> only post-0x200 words delivered; o_inst_pc = 0x200,0x204.
REQ-041 Bypass build vs non-bypass build, empty FIFO, response at cycle N -> o_inst_valid at cycle N (defined) vs N+1 (undefined).
